// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Brief    : Shared seven-segment constants and capture FSM states.
// Revision : 1.0
// ============================================================================
package seg7_pkg;

  // Active-low segment patterns, bit 0 = segment a, bit 6 = segment g
  localparam logic [6:0] c_seg_0 = 7'h40;
  localparam logic [6:0] c_seg_1 = 7'h79;
  localparam logic [6:0] c_seg_2 = 7'h24;
  localparam logic [6:0] c_seg_3 = 7'h30;
  localparam logic [6:0] c_seg_4 = 7'h19;
  localparam logic [6:0] c_seg_5 = 7'h12;
  localparam logic [6:0] c_seg_6 = 7'h02;
  localparam logic [6:0] c_seg_7 = 7'h78;
  localparam logic [6:0] c_seg_8 = 7'h00;
  localparam logic [6:0] c_seg_9 = 7'h10;
  localparam logic [6:0] c_seg_a = 7'h08;
  localparam logic [6:0] c_seg_b = 7'h03;
  localparam logic [6:0] c_seg_c = 7'h46;
  localparam logic [6:0] c_seg_d = 7'h21;
  localparam logic [6:0] c_seg_e = 7'h06;
  localparam logic [6:0] c_seg_f = 7'h0E;

  localparam logic [3:0] c_enable_blank = 4'b1111;

  typedef enum logic [1:0] {
    ST_WAIT     = 2'd0,
    ST_SETTLING = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decode
// Brief    : Active-low 7-segment pattern to hex nibble, with validity flag.
// Revision : 1.0
// ============================================================================
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_ledout,
  output logic       o_valid,
  output logic [3:0] o_nibble
);

  always_comb begin
    o_valid  = 1'b1;
    o_nibble = 4'h0;
    case (i_ledout)
      c_seg_0: o_nibble = 4'h0;
      c_seg_1: o_nibble = 4'h1;
      c_seg_2: o_nibble = 4'h2;
      c_seg_3: o_nibble = 4'h3;
      c_seg_4: o_nibble = 4'h4;
      c_seg_5: o_nibble = 4'h5;
      c_seg_6: o_nibble = 4'h6;
      c_seg_7: o_nibble = 4'h7;
      c_seg_8: o_nibble = 4'h8;
      c_seg_9: o_nibble = 4'h9;
      c_seg_a: o_nibble = 4'hA;
      c_seg_b: o_nibble = 4'hB;
      c_seg_c: o_nibble = 4'hC;
      c_seg_d: o_nibble = 4'hD;
      c_seg_e: o_nibble = 4'hE;
      c_seg_f: o_nibble = 4'hF;
      default: o_valid  = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_capture.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_capture
// Brief    : Samples a multiplexed 7-segment bus and rebuilds the 16-bit value.
// Revision : 1.0
// ============================================================================
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int unsigned SETTLE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  enable,
  input  logic [6:0]  ledout,
  output logic [15:0] value,
  output logic        frame_valid,
  output logic        changed,
  output logic        seg_err
);

  localparam logic [7:0] c_settle    = 8'(SETTLE);
  localparam logic [7:0] c_settle_m1 = 8'(SETTLE - 1);

  logic [10:0]     r_s;
  logic [10:0]     r_p;
  logic [7:0]      r_cnt;
  state_t          r_state;
  state_t          w_state_next;
  logic [3:0][3:0] r_slots;
  logic [3:0]      r_mask;
  logic [15:0]     r_value;
  logic            r_frame_valid;
  logic            r_changed;
  logic            r_seg_err;

  logic [3:0]      w_s_en;
  logic [6:0]      w_s_led;
  logic            w_stable;
  logic            w_settled;
  logic            w_onehot;
  logic            w_blank;
  logic            w_illegal;
  logic [1:0]      w_digit;
  logic            w_capture;
  logic            w_enable_err;
  logic            w_dec_valid;
  logic [3:0]      w_dec_nibble;
  logic [3:0][3:0] w_slots_new;
  logic [3:0]      w_mask_new;

  assign w_s_en    = r_s[10:7];
  assign w_s_led   = r_s[6:0];
  assign w_stable  = (r_s == r_p);
  assign w_settled = w_stable && (r_cnt >= c_settle_m1);
  assign w_blank   = (w_s_en == c_enable_blank);
  assign w_illegal = !w_onehot && !w_blank;

  always_comb begin
    w_onehot = 1'b1;
    w_digit  = 2'd0;
    case (w_s_en)
      4'b1110: w_digit = 2'd0;
      4'b1101: w_digit = 2'd1;
      4'b1011: w_digit = 2'd2;
      4'b0111: w_digit = 2'd3;
      default: w_onehot = 1'b0;
    endcase
  end

  seg7_decode u_decode (
    .i_ledout (w_s_led),
    .o_valid  (w_dec_valid),
    .o_nibble (w_dec_nibble)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s   <= '1;
      r_p   <= '1;
      r_cnt <= 8'd0;
    end else begin
      r_s <= {enable, ledout};
      r_p <= r_s;
      if (!w_stable) begin
        r_cnt <= 8'd0;
      end else if (r_cnt != c_settle) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_WAIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // WAIT may act directly so every phase needs the same number of samples,
  // whichever state it started in.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_enable_err = 1'b0;
    case (r_state)
      ST_WAIT: begin
        if (w_onehot) begin
          if (w_settled) begin
            w_capture    = 1'b1;
            w_state_next = ST_HELD;
          end else begin
            w_state_next = ST_SETTLING;
          end
        end else if (w_illegal && w_settled) begin
          w_enable_err = 1'b1;
          w_state_next = ST_HELD;
        end
      end
      ST_SETTLING: begin
        if (!w_stable) begin
          w_state_next = ST_WAIT;
        end else if (w_settled) begin
          w_capture    = 1'b1;
          w_state_next = ST_HELD;
        end
      end
      ST_HELD: begin
        if (!w_stable) begin
          w_state_next = ST_WAIT;
        end
      end
      default: w_state_next = ST_WAIT;
    endcase
  end

  always_comb begin
    w_slots_new          = r_slots;
    w_slots_new[w_digit] = w_dec_nibble;
    w_mask_new           = r_mask | (4'b0001 << w_digit);
  end

  // The completing capture publishes the merged slots on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_slots       <= '0;
      r_mask        <= 4'd0;
      r_value       <= 16'd0;
      r_frame_valid <= 1'b0;
      r_changed     <= 1'b0;
      r_seg_err     <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_changed     <= 1'b0;
      r_seg_err     <= 1'b0;
      if (w_capture && w_dec_valid) begin
        r_slots <= w_slots_new;
        if (w_mask_new == 4'b1111) begin
          r_mask        <= 4'd0;
          r_value       <= w_slots_new;
          r_frame_valid <= 1'b1;
          r_changed     <= (w_slots_new != r_value);
        end else begin
          r_mask <= w_mask_new;
        end
      end else if ((w_capture && !w_dec_valid) || w_enable_err) begin
        r_seg_err <= 1'b1;
      end
    end
  end

  assign value       = r_value;
  assign frame_valid = r_frame_valid;
  assign changed     = r_changed;
  assign seg_err     = r_seg_err;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_capture
// Brief    : Randomised scoreboard bench for seg7_scan_capture.
// Revision : 1.0
// ============================================================================
module tb_seg7_scan_capture;

  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  enable = 4'hF;
  logic [6:0]  ledout = 7'h7F;
  logic [15:0] value;
  logic        frame_valid;
  logic        changed;
  logic        seg_err;

  always #5 clk = ~clk;

  seg7_scan_capture #(.SETTLE(SETTLE)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .ledout      (ledout),
    .value       (value),
    .frame_valid (frame_valid),
    .changed     (changed),
    .seg_err     (seg_err)
  );

  typedef struct packed {
    logic        is_err;
    logic [15:0] value;
    logic        changed;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [3:0]  m_slots [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
  logic [3:0]  m_mask = 4'h0;
  logic [15:0] m_last = 16'h0;
  logic [10:0] last_drive = 11'h7FF;

  // A phase is one run of an unchanging {enable, ledout}; only runs longer
  // than SETTLE cycles are acted upon.
  task automatic present(input logic [3:0] en, input logic [6:0] led, input int len);
    int          dig;
    int          nib;
    logic [15:0] v;
    if (len > SETTLE && en != 4'hF) begin
      if ($countones(~en) == 1) begin
        dig = 0;
        for (int i = 0; i < 4; i++) if (!en[i]) dig = i;
        nib = -1;
        for (int j = 0; j < 16; j++) if (seg_tab[j] == led) nib = j;
        if (nib < 0) begin
          exp_q.push_back('{1'b1, 16'h0, 1'b0});
        end else begin
          m_slots[dig] = 4'(nib);
          m_mask[dig]  = 1'b1;
          if (m_mask == 4'hF) begin
            v = {m_slots[3], m_slots[2], m_slots[1], m_slots[0]};
            exp_q.push_back('{1'b0, v, v != m_last});
            m_last = v;
            m_mask = 4'h0;
          end
        end
      end else begin
        exp_q.push_back('{1'b1, 16'h0, 1'b0});
      end
    end
    enable     = en;
    ledout     = led;
    last_drive = {en, led};
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if (value !== 16'h0 || frame_valid !== 1'b0 || changed !== 1'b0 || seg_err !== 1'b0) begin
      failures++;
      $display("FAIL %s outputs: value=%h fv=%b ch=%b err=%b required all zero",
               tag, value, frame_valid, changed, seg_err);
    end
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    check_idle("reset_async");
    enable     = 4'hF;
    ledout     = 7'h7F;
    last_drive = 11'h7FF;
    m_mask     = 4'h0;
    m_last     = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset_held");
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    ev_t ev;
    if (reset && (frame_valid || seg_err || changed)) begin
      checks++;
      if (frame_valid && seg_err) begin
        failures++;
        $display("FAIL pulse_overlap: frame_valid=1 seg_err=1 required never both");
      end else if (changed && !frame_valid) begin
        failures++;
        $display("FAIL orphan_changed: changed=1 frame_valid=0 required changed only with frame_valid");
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: fv=%b err=%b value=%h required no event", frame_valid, seg_err, value);
      end else begin
        ev = exp_q.pop_front();
        if (ev.is_err && !seg_err) begin
          failures++;
          $display("FAIL event_kind: got frame value=%h required seg_err", value);
        end else if (!ev.is_err && (!frame_valid || value !== ev.value || changed !== ev.changed)) begin
          failures++;
          $display("FAIL frame: fv=%b value=%h changed=%b required fv=1 value=%h changed=%b",
                   frame_valid, value, changed, ev.value, ev.changed);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] en;
    logic [6:0] led;
    int         len;
    int         r;

    #1;
    check_idle("reset_start");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // basic frame then identical repeat
    for (int k = 0; k < 2; k++) begin
      present(4'b1110, 7'h19, 8);
      present(4'b1101, 7'h30, 8);
      present(4'b1011, 7'h24, 8);
      present(4'b0111, 7'h79, 8);
    end

    // glitch inside a phase, then blanking between phases
    present(4'b1110, 7'h19, 3);
    present(4'b1110, 7'h7F, 2);
    present(4'b1110, 7'h12, 8);
    present(4'b1111, 7'h7F, 8);
    present(4'b1101, 7'h30, 8);
    present(4'b1111, 7'h7F, 8);
    present(4'b1011, 7'h24, 8);
    present(4'b1111, 7'h7F, 8);
    present(4'b0111, 7'h79, 8);

    // illegal enable and undecodable segments, then a frame to show the mask survived
    present(4'b1100, 7'h19, 8);
    present(4'b1110, 7'h55, 8);
    present(4'b1101, 7'h02, 8);
    present(4'b1110, 7'h78, 8);
    present(4'b1011, 7'h00, 8);
    present(4'b0111, 7'h10, 8);

    // reset after two digits discards the partial frame
    present(4'b1110, 7'h08, 8);
    present(4'b1101, 7'h03, 8);
    do_reset();
    present(4'b1110, 7'h46, 8);
    present(4'b1101, 7'h21, 8);
    present(4'b1011, 7'h06, 8);
    present(4'b0111, 7'h0E, 8);

    for (int n = 0; n < 120; n++) begin
      do begin
        r = int'($urandom_range(0, 99));
        if (r < 75)      en = ~(4'b0001 << $urandom_range(0, 3));
        else if (r < 88) en = 4'hF;
        else             en = 4'($urandom_range(0, 15));
        r   = int'($urandom_range(0, 99));
        led = (r < 90) ? seg_tab[$urandom_range(0, 15)] : 7'($urandom);
        len = ($urandom_range(0, 99) < 20) ? int'($urandom_range(1, SETTLE - 1))
                                           : int'($urandom_range(SETTLE + 2, SETTLE + 6));
      end while ({en, led} == last_drive);
      present(en, led, len);
    end

    present(4'hF, (last_drive == 11'h7FF) ? 7'h00 : 7'h7F, 20);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events: %0d expected events never seen, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
